sd_sector_scheduler: RTL and testbench
======================================

Name: sd_sector_scheduler

Overview:
- Sits between the SD SPI sector reader and its two consumers: the video fetch path and the audio fetch path.
- Arbitrates round-robin between the two sector requests and issues one 512-byte sector read at a time.
- Generates each requester's sector address from a configurable base/length window that wraps, so files stream in a loop.
- Forwards the returned byte stream tagged with its owner, and aborts/retries sectors that stall.

Parameters:
ADDR_W, 24, sector address width (matches SD reader address input)
SECTOR_BYTES, 512, bytes per sector read
TIMEOUT, 1000000, MasterCLK cycles allowed between command accept/byte and the next byte

Ports:
MasterCLK  in  1  system clock; single clock domain
Reset  in  1  synchronous, active-high reset
sd_init_done  in  1  SD reader finished card initialisation
sd_cmd_valid  out  1  read command pending
sd_cmd_addr  out  ADDR_W  sector address for pending command
sd_cmd_ready  in  1  SD reader accepts command this cycle
sd_byte_valid  in  1  one-cycle strobe, sd_byte valid (already in MasterCLK domain)
sd_byte  in  8  data byte from card
req_vid  in  1  video requests a sector (level)
req_aud  in  1  audio requests a sector (level)
vid_base  in  ADDR_W  video window first sector
vid_len  in  ADDR_W  video window length in sectors
aud_base  in  ADDR_W  audio window first sector
aud_len  in  ADDR_W  audio window length in sectors
grant  out  2  one-hot owner of current transfer: bit0 video, bit1 audio
out_valid  out  1  forwarded byte strobe
out_data  out  8  forwarded byte
out_last  out  1  with out_valid on final byte of sector
out_owner  out  1  0 video, 1 audio; valid with out_valid
timeout_err  out  1  sticky stall flag
busy  out  1  transfer in progress

Behaviour:
- Reset values:
  - outputs: sd_cmd_valid=0, sd_cmd_addr=0, grant=0, out_valid=0, out_data=0, out_last=0, out_owner=0, timeout_err=0, busy=0.
  - internal state: vid_off=0, aud_off=0, last_owner=1 (video wins first tie), byte counter=0, timeout counter=0.
- State machine is IDLE -> ISSUE -> STREAM -> DONE -> IDLE.
- IDLE:
  - Does nothing while sd_init_done=0.
  - Otherwise, if exactly one request is high, grant it. If both are high, grant the requester that is not last_owner.
  - Next cycle: ISSUE with sd_cmd_valid=1, busy=1, and sd_cmd_addr=base+off of the owner. Addition truncates to ADDR_W.
- ISSUE:
  - sd_cmd_valid and sd_cmd_addr are held until a cycle with sd_cmd_ready=1.
  - In that cycle the command is accepted; next cycle sd_cmd_valid=0 and the state is STREAM.
  - The timeout counter does not run in ISSUE.
- STREAM:
  - Each sd_byte_valid yields, one cycle later: out_valid=1, out_data=sd_byte, out_owner=owner.
  - The byte counter increments on each sd_byte_valid. out_last=1 on byte SECTOR_BYTES-1.
  - After that byte, the state goes to DONE. Extra sd_byte_valid pulses in DONE/IDLE are ignored.
- DONE (1 cycle):
  - Owner offset advances: off <= (off == len-1) ? 0 : off+1. len=0 is treated as 1, so off stays 0.
  - last_owner <= owner; grant=0, busy=0; then IDLE.
- Back-to-back: a requester still high in IDLE is re-arbitrated immediately. There is no lockout beyond the round-robin rule.
- Request deassert mid-transfer is ignored; the sector completes and is delivered.
- Timeout:
  - The counter clears on command accept and on every sd_byte_valid, and counts in STREAM.
  - On reaching TIMEOUT-1: timeout_err <= 1 (sticky until Reset), abort to IDLE, grant=0, byte counter=0.
  - The offset is NOT advanced (the sector is retried), and last_owner is NOT updated.
  - Bytes already forwarded from the aborted sector are not retracted. out_last is never asserted for it.
- Base/len changes take effect on the next address computation. The offset is not reset; if off >= new len, the next DONE wraps off to 0.
- Reset mid-operation returns everything to the reset values in the next cycle. Any in-flight SD command is abandoned.

Test Plan:
1. sd_init_done=0, req_vid=1 for 100 cycles -> sd_cmd_valid stays 0, grant=0.
2. Init done, vid_base=0x000100, vid_len=3, req_vid held, reader returns 512 bytes per command -> addresses 0x100, 0x101, 0x102, 0x100. Exactly 512 out_valid per sector, out_last on the 512th, out_owner=0.
3. req_vid=req_aud=1 continuously, aud_base=0x2000 -> grants alternate video, audio, video. First command addr 0x100, second 0x2000.
4. sd_cmd_ready held low 50 cycles, then pulsed -> sd_cmd_valid high, sd_cmd_addr stable for all 50 cycles; deasserts the cycle after accept.
5. TIMEOUT=100; reader stops after byte 200 -> timeout_err=1 after 100 idle cycles, no out_last. The retry command reuses the same address, and the next full sector advances the offset.
6. Reset asserted at byte 300 of a sector -> next cycle busy=0, grant=0, sd_cmd_valid=0. The following video command uses vid_base (offset 0).

Source files
------------

// File: rtl/sd_sector_scheduler_if.sv
// Signal bundle between the sector scheduler, the SD SPI sector reader and the video/audio fetch paths.
interface sd_sector_scheduler_if #(
  parameter int ADDR_W = 24
);
  logic              sd_init_done;
  logic              sd_cmd_valid;
  logic [ADDR_W-1:0] sd_cmd_addr;
  logic              sd_cmd_ready;
  logic              sd_byte_valid;
  logic [7:0]        sd_byte;
  logic              req_vid;
  logic              req_aud;
  logic [ADDR_W-1:0] vid_base;
  logic [ADDR_W-1:0] vid_len;
  logic [ADDR_W-1:0] aud_base;
  logic [ADDR_W-1:0] aud_len;
  logic [1:0]        grant;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_last;
  logic              out_owner;
  logic              timeout_err;
  logic              busy;

  modport master (
    input  sd_init_done, sd_cmd_ready, sd_byte_valid, sd_byte,
           req_vid, req_aud, vid_base, vid_len, aud_base, aud_len,
    output sd_cmd_valid, sd_cmd_addr, grant, out_valid, out_data,
           out_last, out_owner, timeout_err, busy
  );

  modport slave (
    output sd_init_done, sd_cmd_ready, sd_byte_valid, sd_byte,
           req_vid, req_aud, vid_base, vid_len, aud_base, aud_len,
    input  sd_cmd_valid, sd_cmd_addr, grant, out_valid, out_data,
           out_last, out_owner, timeout_err, busy
  );
endinterface

// File: rtl/sd_sector_scheduler.sv
// Round-robin video/audio sector scheduler: one sector read at a time from wrapping per-requester
// windows, owner-tagged byte forwarding one cycle after each SD byte, stall abort with retry.
module sd_sector_scheduler #(
  parameter int ADDR_W       = 24,
  parameter int SECTOR_BYTES = 512,
  parameter int TIMEOUT      = 1000000
) (
  input  logic                 MasterCLK,
  input  logic                 Reset,
  sd_sector_scheduler_if.master bus
);
  localparam int BCW = $clog2(SECTOR_BYTES);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0]    LAST_BYTE = BCW'(SECTOR_BYTES - 1);
  localparam logic [TCW-1:0]    TMO_LIMIT = TCW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] vid_off_q, vid_off_d;
  logic [ADDR_W-1:0] aud_off_q, aud_off_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [TCW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_owner_q, out_owner_d;
  logic              timeout_err_q, timeout_err_d;

  logic any_req;
  logic pick;

  // A zero-length window behaves as one sector, and an offset left beyond a shrunk window wraps.
  function automatic logic [ADDR_W-1:0] next_off(input logic [ADDR_W-1:0] off,
                                                 input logic [ADDR_W-1:0] len);
    logic [ADDR_W-1:0] lim;
    lim = (len == '0) ? '0 : len - ADDR_ONE;
    return (off >= lim) ? '0 : off + ADDR_ONE;
  endfunction

  assign any_req = bus.req_vid | bus.req_aud;
  assign pick    = (bus.req_vid & bus.req_aud) ? ~last_owner_q : bus.req_aud;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    vid_off_d     = vid_off_q;
    aud_off_d     = aud_off_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_addr_d    = cmd_addr_q;
    grant_d       = grant_q;
    busy_d        = busy_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    out_last_d    = 1'b0;
    out_owner_d   = out_owner_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.sd_init_done && any_req) begin
          owner_d     = pick;
          grant_d     = pick ? 2'b10 : 2'b01;
          busy_d      = 1'b1;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = pick ? bus.aud_base + aud_off_q : bus.vid_base + vid_off_q;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.sd_cmd_ready) begin
          cmd_valid_d = 1'b0;
          tmo_cnt_d   = '0;
          byte_cnt_d  = '0;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (bus.sd_byte_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.sd_byte;
          out_owner_d = owner_q;
          tmo_cnt_d   = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            out_last_d = 1'b1;
            byte_cnt_d = '0;
            state_d    = S_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end else if (tmo_cnt_q == TMO_LIMIT) begin
          // Abort without touching offset or last_owner so the same sector is retried.
          timeout_err_d = 1'b1;
          grant_d       = 2'b00;
          busy_d        = 1'b0;
          byte_cnt_d    = '0;
          tmo_cnt_d     = '0;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
      end
      S_DONE: begin
        if (owner_q) aud_off_d = next_off(aud_off_q, bus.aud_len);
        else         vid_off_d = next_off(vid_off_q, bus.vid_len);
        last_owner_d = owner_q;
        grant_d      = 2'b00;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      vid_off_q     <= '0;
      aud_off_q     <= '0;
      byte_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_addr_q    <= '0;
      grant_q       <= 2'b00;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'h00;
      out_last_q    <= 1'b0;
      out_owner_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      vid_off_q     <= vid_off_d;
      aud_off_q     <= aud_off_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_addr_q    <= cmd_addr_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_owner_q   <= out_owner_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.sd_cmd_valid = cmd_valid_q;
  assign bus.sd_cmd_addr  = cmd_addr_q;
  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_owner    = out_owner_q;
  assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_sd_sector_scheduler.sv
// Directed bench for sd_sector_scheduler with a transaction-level model checked every cycle.
module tb_sd_sector_scheduler;
  localparam int TMO  = 100;
  localparam int SECT = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_sector_scheduler_if #(.ADDR_W(24)) bus ();

  sd_sector_scheduler #(.ADDR_W(24), .SECTOR_BYTES(SECT), .TIMEOUT(TMO)) dut (
    .MasterCLK(clk),
    .Reset    (rst),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int seq     = 0;
  int ov_cnt  = 0;
  int last_cnt = 0;
  logic [23:0] acc_addr[$];
  logic [1:0]  acc_grant[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: sector offsets, round-robin history, transfer progress.
  logic [23:0] m_off[2] = '{24'd0, 24'd0};
  logic        m_last_owner = 1'b1;
  logic        m_cmd_pend = 1'b0;
  logic        m_cmd_owner = 1'b0;
  logic [23:0] m_cmd_addr = '0;
  logic        m_streaming = 1'b0;
  logic        m_owner = 1'b0;
  int          m_cnt = 0;
  int          m_idle = 0;
  logic        exp_ov = 1'b0, exp_last = 1'b0, exp_own = 1'b0, exp_tmo = 1'b0;
  logic [7:0]  exp_dat = 8'h00;

  function automatic logic [23:0] wrap_off(input logic [23:0] off, input logic [23:0] len);
    if (len == 24'd0) return 24'd0;
    if (int'(off) + 1 >= int'(len)) return 24'd0;
    return off + 24'd1;
  endfunction

  always @(negedge clk) begin
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check("out_data", 32'(bus.out_data), 32'(exp_dat));
      check("out_last", 32'(bus.out_last), 32'(exp_last));
      check("out_owner", 32'(bus.out_owner), 32'(exp_own));
    end
    check("timeout_err", 32'(bus.timeout_err), 32'(exp_tmo));
    if (bus.out_valid === 1'b1) ov_cnt++;
    if (bus.out_valid === 1'b1 && bus.out_last === 1'b1) last_cnt++;
    exp_ov = 1'b0;
    if (rst) begin
      m_off = '{24'd0, 24'd0};
      m_last_owner = 1'b1;
      m_cmd_pend = 1'b0;
      m_streaming = 1'b0;
      m_cnt = 0;
      m_idle = 0;
      exp_tmo = 1'b0;
    end else begin
      if (bus.sd_cmd_valid === 1'b1) begin
        if (!m_cmd_pend) begin
          m_cmd_pend  = 1'b1;
          m_cmd_owner = (bus.req_vid && bus.req_aud) ? ~m_last_owner : bus.req_aud;
          m_cmd_addr  = m_cmd_owner ? 24'(bus.aud_base + m_off[1]) : 24'(bus.vid_base + m_off[0]);
        end
        check("cmd_addr", 32'(bus.sd_cmd_addr), 32'(m_cmd_addr));
        check("cmd_grant", 32'(bus.grant), m_cmd_owner ? 32'd2 : 32'd1);
        check("cmd_busy", 32'(bus.busy), 32'd1);
      end
      if (m_streaming) begin
        check("cmd_valid_in_stream", 32'(bus.sd_cmd_valid), 32'd0);
        if (bus.sd_byte_valid) begin
          m_cnt++;
          m_idle   = 0;
          exp_ov   = 1'b1;
          exp_dat  = bus.sd_byte;
          exp_own  = m_owner;
          exp_last = (m_cnt == SECT);
          if (m_cnt == SECT) begin
            m_streaming = 1'b0;
            m_off[m_owner] = wrap_off(m_off[m_owner], m_owner ? bus.aud_len : bus.vid_len);
            m_last_owner = m_owner;
          end
        end else begin
          m_idle++;
          if (m_idle == TMO) begin
            m_streaming = 1'b0;
            exp_tmo = 1'b1;
          end
        end
      end else if (m_cmd_pend && bus.sd_cmd_valid === 1'b1 && bus.sd_cmd_ready) begin
        m_cmd_pend  = 1'b0;
        m_streaming = 1'b1;
        m_owner     = m_cmd_owner;
        m_cnt       = 0;
        m_idle      = 0;
      end
    end
  end

  // SD reader stand-in: wait for a command, accept it after rdy_delay cycles, return nbytes.
  task automatic serve_sector(input int nbytes, input int rdy_delay, input int gap, input bit drop);
    int  t;
    bit  held;
    t = 0;
    while (bus.sd_cmd_valid !== 1'b1 && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    check("cmd_wait", 32'(bus.sd_cmd_valid), 32'd1);
    if (bus.sd_cmd_valid !== 1'b1) return;
    acc_addr.push_back(bus.sd_cmd_addr);
    acc_grant.push_back(bus.grant);
    held = 1'b1;
    for (int i = 0; i < rdy_delay; i++) begin
      @(posedge clk); #1;
      if (bus.sd_cmd_valid !== 1'b1 || bus.sd_cmd_addr !== acc_addr[$]) held = 1'b0;
    end
    if (rdy_delay > 0) check("cmd_hold", 32'(held), 32'd1);
    bus.sd_cmd_ready = 1'b1;
    @(posedge clk); #1;
    bus.sd_cmd_ready = 1'b0;
    check("cmd_deassert", 32'(bus.sd_cmd_valid), 32'd0);
    if (drop) begin
      bus.req_vid = 1'b0;
      bus.req_aud = 1'b0;
    end
    for (int i = 0; i < nbytes; i++) begin
      bus.sd_byte_valid = 1'b1;
      bus.sd_byte = 8'(i * 7 + seq * 13);
      @(posedge clk); #1;
      bus.sd_byte_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
    seq++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  ov0, last0;
    bit  quiet;
    bus.sd_init_done = 1'b0; bus.sd_cmd_ready = 1'b0;
    bus.sd_byte_valid = 1'b0; bus.sd_byte = 8'h00;
    bus.req_vid = 1'b0; bus.req_aud = 1'b0;
    bus.vid_base = 24'h000100; bus.vid_len = 24'd3;
    bus.aud_base = 24'h002000; bus.aud_len = 24'd2;
    cycles(3);
    check("rst_cmd_valid", 32'(bus.sd_cmd_valid), 32'd0);
    check("rst_cmd_addr",  32'(bus.sd_cmd_addr),  32'd0);
    check("rst_grant",     32'(bus.grant),        32'd0);
    check("rst_out_valid", 32'(bus.out_valid),    32'd0);
    check("rst_out_data",  32'(bus.out_data),     32'd0);
    check("rst_out_last",  32'(bus.out_last),     32'd0);
    check("rst_out_owner", 32'(bus.out_owner),    32'd0);
    check("rst_timeout",   32'(bus.timeout_err),  32'd0);
    check("rst_busy",      32'(bus.busy),         32'd0);
    rst = 1'b0;

    // 1: no activity before card init
    bus.req_vid = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (bus.sd_cmd_valid !== 1'b0 || bus.grant !== 2'b00) quiet = 1'b0;
    end
    check("t1_no_cmd_before_init", 32'(quiet), 32'd1);

    // 2: video window wraps 0x100,0x101,0x102,0x100
    acc_addr.delete(); acc_grant.delete();
    ov0 = ov_cnt; last0 = last_cnt;
    bus.sd_init_done = 1'b1;
    serve_sector(SECT, 0, 0, 0);
    serve_sector(SECT, 0, 0, 0);
    serve_sector(SECT, 0, 0, 0);
    serve_sector(SECT, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin   // stray bytes while idle must not be forwarded
      bus.sd_byte_valid = 1'b1; bus.sd_byte = 8'hEE; cycles(1);
      bus.sd_byte_valid = 1'b0; cycles(1);
    end
    cycles(2);
    check("t2_ncmd", 32'(acc_addr.size()), 32'd4);
    if (acc_addr.size() == 4) begin
      check("t2_addr0", 32'(acc_addr[0]), 32'h100);
      check("t2_addr1", 32'(acc_addr[1]), 32'h101);
      check("t2_addr2", 32'(acc_addr[2]), 32'h102);
      check("t2_addr3", 32'(acc_addr[3]), 32'h100);
      check("t2_grant3", 32'(acc_grant[3]), 32'd1);
    end
    check("t2_out_valid_count", 32'(ov_cnt - ov0), 32'(4 * SECT));
    check("t2_out_last_count", 32'(last_cnt - last0), 32'd4);

    // 3: both requesting alternates video/audio from a fresh reset
    rst = 1'b1; cycles(2); rst = 1'b0;
    acc_addr.delete(); acc_grant.delete();
    bus.req_vid = 1'b1; bus.req_aud = 1'b1;
    serve_sector(SECT, 0, 0, 0);
    serve_sector(SECT, 0, 0, 0);
    serve_sector(SECT, 0, 0, 1);
    check("t3_ncmd", 32'(acc_addr.size()), 32'd3);
    if (acc_addr.size() == 3) begin
      check("t3_addr0", 32'(acc_addr[0]), 32'h100);
      check("t3_addr1", 32'(acc_addr[1]), 32'h2000);
      check("t3_addr2", 32'(acc_addr[2]), 32'h101);
      check("t3_grant0", 32'(acc_grant[0]), 32'd1);
      check("t3_grant1", 32'(acc_grant[1]), 32'd2);
      check("t3_grant2", 32'(acc_grant[2]), 32'd1);
    end

    // 4: command held 50 cycles against a stalled reader, bytes with gaps
    acc_addr.delete(); acc_grant.delete();
    bus.req_vid = 1'b1;
    serve_sector(SECT, 50, 1, 1);
    check("t4_addr", 32'(acc_addr[0]), 32'h102);

    // 5: stall after 200 bytes, then retry of the same sector
    acc_addr.delete(); acc_grant.delete();
    last0 = last_cnt;
    bus.req_vid = 1'b1;
    serve_sector(200, 0, 0, 0);
    k = 0;
    while (bus.timeout_err !== 1'b1 && k < 300) begin
      cycles(1); k++;
    end
    check("t5_timeout_latency", 32'(k), 32'd100);
    check("t5_abort_grant", 32'(bus.grant), 32'd0);
    check("t5_abort_busy", 32'(bus.busy), 32'd0);
    check("t5_no_last", 32'(last_cnt - last0), 32'd0);
    serve_sector(SECT, 0, 0, 0);
    serve_sector(SECT, 0, 0, 1);
    check("t5_ncmd", 32'(acc_addr.size()), 32'd3);
    if (acc_addr.size() == 3) begin
      check("t5_addr_abort", 32'(acc_addr[0]), 32'h100);
      check("t5_addr_retry", 32'(acc_addr[1]), 32'h100);
      check("t5_addr_next", 32'(acc_addr[2]), 32'h101);
    end

    // 6: reset in the middle of a sector
    acc_addr.delete(); acc_grant.delete();
    bus.req_vid = 1'b1;
    serve_sector(300, 0, 0, 0);
    rst = 1'b1;
    cycles(1);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_grant", 32'(bus.grant), 32'd0);
    check("t6_cmd_valid", 32'(bus.sd_cmd_valid), 32'd0);
    check("t6_timeout_cleared", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
    serve_sector(SECT, 0, 0, 1);
    check("t6_ncmd", 32'(acc_addr.size()), 32'd2);
    if (acc_addr.size() == 2) begin
      check("t6_addr_before", 32'(acc_addr[0]), 32'h102);
      check("t6_addr_after", 32'(acc_addr[1]), 32'h100);
    end

    // 7: zero-length audio window stays on its base sector
    acc_addr.delete(); acc_grant.delete();
    bus.aud_base = 24'h003000; bus.aud_len = 24'd0;
    bus.req_aud = 1'b1;
    serve_sector(SECT, 0, 0, 0);
    serve_sector(SECT, 0, 0, 1);
    check("t7_ncmd", 32'(acc_addr.size()), 32'd2);
    if (acc_addr.size() == 2) begin
      check("t7_addr0", 32'(acc_addr[0]), 32'h3000);
      check("t7_addr1", 32'(acc_addr[1]), 32'h3000);
      check("t7_grant", 32'(acc_grant[1]), 32'd2);
    end

    cycles(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
